// File: rtl/cadr_clk_pkg.sv
// cadr_clk_pkg: shared types and default constants for the CADR clock sequencer.
// Holds the sequencer state encoding and default cycle-shape constants.
// Optional build macro used by the top: CADR_CLOCK_STEP_COUNT_EN.
package cadr_clk_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } clk_state_e;

    localparam int CYCLE_LEN_DEF  = 4;
    localparam int LONG_EXTRA_DEF = 2;
    localparam int WP_PHASE_DEF   = 2;
    localparam int PHW_DEF        = 4;

endpackage

// File: rtl/cadr_clk_phase.sv
// cadr_clk_phase: machine-cycle phase counter with wait-hold, long-cycle latch
// and tpclk/tpwp strobe generation.
// Ports: clk, reset_n (async, active-low), active_i (sequencer not halted),
//   long_cyc_i, wait_req_i -> phase_o, tpclk_o (registered), tpwp_o, wrap_o.
module cadr_clk_phase
    import cadr_clk_pkg::*;
#(
    parameter int CYCLE_LEN  = CYCLE_LEN_DEF,
    parameter int LONG_EXTRA = LONG_EXTRA_DEF,
    parameter int WP_PHASE   = WP_PHASE_DEF,
    parameter int PHW        = PHW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           active_i,
    input  logic           long_cyc_i,
    input  logic           wait_req_i,
    output logic [PHW-1:0] phase_o,
    output logic           tpclk_o,
    output logic           tpwp_o,
    output logic           wrap_o
);

    localparam logic [PHW-1:0] LAST_N = PHW'(CYCLE_LEN - 1);
    localparam logic [PHW-1:0] LAST_L = PHW'(CYCLE_LEN + LONG_EXTRA - 1);
    localparam logic [PHW-1:0] WP     = PHW'(WP_PHASE);

    logic [PHW-1:0] phase_q, phase_d;
    logic           long_q, long_d;
    logic           held_q, held_d;
    logic           tpclk_q;
    logic           at_last;

    always_comb begin
        at_last = (phase_q == (long_q ? LAST_L : LAST_N));
        wrap_o  = active_i & at_last & ~wait_req_i;
        phase_d = phase_q;
        long_d  = long_q;
        held_d  = 1'b0;
        if (!active_i) begin
            phase_d = '0;
        end else if (at_last) begin
            // wait_req only stretches the final phase
            if (!wait_req_i) phase_d = '0;
            held_d = wait_req_i;
        end else begin
            phase_d = phase_q + PHW'(1);
        end
        // cycle length is fixed by long_cyc as seen during phase 0
        if (active_i && phase_q == '0) long_d = long_cyc_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
            tpclk_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            long_q  <= long_d;
            held_q  <= held_d;
            tpclk_q <= wrap_o;
        end
    end

    // held_q suppresses a repeat write pulse if WP_PHASE is the stretched phase
    assign tpwp_o  = active_i & (phase_q == WP) & ~held_q;
    assign tpclk_o = tpclk_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/cadr_clock_ctl.sv
// cadr_clock_ctl: CADR machine-cycle sequencer with run/halt/step control,
// sticky error halt, tpclk commit strobe and tpwp write pulse.
// Ports: clk, reset_n, run, halt_req, step_req, long_cyc, wait_req, err,
//   clr_err -> step_ack, tpclk, tpwp, phase, running, halted_err.
// Macro CADR_CLOCK_STEP_COUNT_EN adds step_cnt[15:0]/step_cnt_load (N-cycle run).
module cadr_clock_ctl
    import cadr_clk_pkg::*;
#(
    parameter int CYCLE_LEN  = CYCLE_LEN_DEF,
    parameter int LONG_EXTRA = LONG_EXTRA_DEF,
    parameter int WP_PHASE   = WP_PHASE_DEF,
    parameter int PHW        = PHW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           run,
    input  logic           halt_req,
    input  logic           step_req,
    output logic           step_ack,
    input  logic           long_cyc,
    input  logic           wait_req,
    input  logic           err,
    input  logic           clr_err,
`ifdef CADR_CLOCK_STEP_COUNT_EN
    input  logic [15:0]    step_cnt,
    input  logic           step_cnt_load,
`endif
    output logic           tpclk,
    output logic           tpwp,
    output logic [PHW-1:0] phase,
    output logic           running,
    output logic           halted_err
);

    clk_state_e state_q, state_d;
    logic       step_q;
    logic       err_q, err_d;
    logic       ack_q, ack_d;
    logic       active;
    logic       wrap;
    logic       step_rise;
    logic       stop_run;
`ifdef CADR_CLOCK_STEP_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        abort;
`endif

    assign active    = (state_q != HALT);
    assign step_rise = step_req & ~step_q;
    assign stop_run  = halt_req | ~run | err;
`ifdef CADR_CLOCK_STEP_COUNT_EN
    assign abort     = halt_req | err;
`endif

    cadr_clk_phase #(
        .CYCLE_LEN  (CYCLE_LEN),
        .LONG_EXTRA (LONG_EXTRA),
        .WP_PHASE   (WP_PHASE),
        .PHW        (PHW)
    ) u_phase (
        .clk        (clk),
        .reset_n    (reset_n),
        .active_i   (active),
        .long_cyc_i (long_cyc),
        .wait_req_i (wait_req),
        .phase_o    (phase),
        .tpclk_o    (tpclk),
        .tpwp_o     (tpwp),
        .wrap_o     (wrap)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = err_q;
`ifdef CADR_CLOCK_STEP_COUNT_EN
        cnt_d   = cnt_q;
`endif
        // err beats clr_err when both arrive together
        if (err)          err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;

        unique case (state_q)
            HALT: begin
                if (!err_q && !err) begin
                    if (run) begin
                        state_d = RUN;
                    end else if (step_rise) begin
                        state_d = STEP;
`ifdef CADR_CLOCK_STEP_COUNT_EN
                        cnt_d   = 16'd1;
                    end else if (step_cnt_load && step_cnt != 16'd0) begin
                        state_d = STEP;
                        cnt_d   = step_cnt;
`endif
                    end
                end
            end
            RUN: begin
                // a stop landing on the wrap clock skips DRAIN
                if (stop_run) state_d = wrap ? HALT : DRAIN;
            end
            DRAIN: begin
                if (wrap) state_d = HALT;
            end
            STEP: begin
`ifdef CADR_CLOCK_STEP_COUNT_EN
                if (wrap) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1 || abort) state_d = HALT;
                    ack_d = (cnt_q == 16'd1);
                end else if (abort) begin
                    state_d = DRAIN;
                end
`else
                if (wrap) begin
                    state_d = HALT;
                    ack_d   = 1'b1;
                end
`endif
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HALT;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
`ifdef CADR_CLOCK_STEP_COUNT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_req;
            err_q   <= err_d;
            ack_q   <= ack_d;
`ifdef CADR_CLOCK_STEP_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign step_ack   = ack_q;
    assign running    = (state_q == RUN) || (state_q == DRAIN);
    assign halted_err = err_q;

endmodule

// File: tb/tb_cadr_clock_ctl.sv
// tb_cadr_clock_ctl: directed self-checking bench for cadr_clock_ctl
// (CYCLE_LEN=4, LONG_EXTRA=2, WP_PHASE=2); covers CADR_CLOCK_STEP_COUNT_EN if set.
module tb_cadr_clock_ctl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, halt_req, step_req, long_cyc, wait_req, err, clr_err;
    logic       step_ack, tpclk, tpwp, running, halted_err;
    logic [3:0] phase;
`ifdef CADR_CLOCK_STEP_COUNT_EN
    logic [15:0] step_cnt;
    logic        step_cnt_load;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cadr_clock_ctl #(
        .CYCLE_LEN  (4),
        .LONG_EXTRA (2),
        .WP_PHASE   (2),
        .PHW        (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .halt_req      (halt_req),
        .step_req      (step_req),
        .step_ack      (step_ack),
        .long_cyc      (long_cyc),
        .wait_req      (wait_req),
        .err           (err),
        .clr_err       (clr_err),
`ifdef CADR_CLOCK_STEP_COUNT_EN
        .step_cnt      (step_cnt),
        .step_cnt_load (step_cnt_load),
`endif
        .tpclk         (tpclk),
        .tpwp          (tpwp),
        .phase         (phase),
        .running       (running),
        .halted_err    (halted_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ph_exp[10] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 0};
    int tp_exp[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    int n_tp, n_wp, n_ack;

    initial begin
        reset_n  = 1'b0;
        run      = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        long_cyc = 1'b0;
        wait_req = 1'b0;
        err      = 1'b0;
        clr_err  = 1'b0;
`ifdef CADR_CLOCK_STEP_COUNT_EN
        step_cnt      = 16'd0;
        step_cnt_load = 1'b0;
`endif
        tick();
        tick();
        chk("rst_phase", 32'(phase), 0);
        chk("rst_tpclk", 32'(tpclk), 0);
        chk("rst_tpwp", 32'(tpwp), 0);
        chk("rst_ack", 32'(step_ack), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_herr", 32'(halted_err), 0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("halt_phase", 32'(phase), 0);

        // free run: 0,1,2,3 repeating
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("run_phase", 32'(phase), 32'(i % 4));
            chk("run_tpclk", 32'(tpclk), 32'(i > 0 && i % 4 == 0));
            chk("run_tpwp", 32'(tpwp), 32'(i % 4 == 2));
        end
        chk("run_running", 32'(running), 1);

        // long cycle then normal cycle
        tick();
        chk("long_pre_phase", 32'(phase), 0);
        long_cyc = 1'b1;
        n_wp = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            long_cyc = 1'b0;
            n_wp += int'(tpwp);
            chk("long_phase", 32'(phase), 32'(ph_exp[i]));
            chk("long_tpclk", 32'(tpclk), 32'(tp_exp[i]));
        end
        chk("long_wp_cnt", 32'(n_wp), 2);

        // wait stretch at phase 3
        tick();
        tick();
        chk("wait_wp_ph2", 32'(tpwp), 1);
        tick();
        chk("wait_ph3", 32'(phase), 3);
        wait_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_hold_phase", 32'(phase), 3);
            chk("wait_hold_tpclk", 32'(tpclk), 0);
            chk("wait_hold_tpwp", 32'(tpwp), 0);
        end
        wait_req = 1'b0;
        tick();
        chk("wait_end_phase", 32'(phase), 0);
        chk("wait_end_tpclk", 32'(tpclk), 1);

        // wait_req away from the last phase is ignored
        wait_req = 1'b1;
        tick();
        chk("wait_ign_phase", 32'(phase), 1);
        wait_req = 1'b0;
        tick();
        tick();
        tick();
        chk("wait_ign_tpclk", 32'(tpclk), 1);

        // run=0 mid-cycle drains the cycle
        run = 1'b0;
        tick();
        chk("drain_phase", 32'(phase), 1);
        chk("drain_running", 32'(running), 1);
        tick();
        tick();
        tick();
        chk("drain_tpclk", 32'(tpclk), 1);
        chk("drain_halted", 32'(running), 0);
        tick();
        chk("drain_idle_phase", 32'(phase), 0);
        chk("drain_idle_tpclk", 32'(tpclk), 0);

        // single step, second pulse mid-step ignored
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_phase0", 32'(phase), 0);
        chk("step_running", 32'(running), 0);
        tick();
        chk("step_phase1", 32'(phase), 1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_tpwp", 32'(tpwp), 1);
        tick();
        chk("step_ack_early", 32'(step_ack), 0);
        tick();
        chk("step_tpclk", 32'(tpclk), 1);
        chk("step_ack", 32'(step_ack), 1);
        chk("step_end_phase", 32'(phase), 0);
        n_tp  = 0;
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tp  += int'(tpclk);
            n_ack += int'(step_ack);
        end
        chk("step2_tpclk_cnt", 32'(n_tp), 0);
        chk("step2_ack_cnt", 32'(n_ack), 0);
        chk("step2_phase", 32'(phase), 0);

        // error at phase 1: cycle completes, then sticky halt
        run = 1'b1;
        tick();
        tick();
        chk("err_ph1", 32'(phase), 1);
        err = 1'b1;
        tick();
        err = 1'b0;
        chk("err_herr", 32'(halted_err), 1);
        chk("err_drain_phase", 32'(phase), 2);
        tick();
        tick();
        chk("err_tpclk", 32'(tpclk), 1);
        chk("err_running", 32'(running), 0);
        n_tp = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tp += int'(tpclk);
        end
        chk("err_blocked_tp", 32'(n_tp), 0);
        chk("err_blocked_run", 32'(running), 0);
        err     = 1'b1;
        clr_err = 1'b1;
        tick();
        chk("err_beats_clr", 32'(halted_err), 1);
        err = 1'b0;
        tick();
        chk("clr_herr", 32'(halted_err), 0);
        chk("clr_still_halt", 32'(running), 0);
        clr_err = 1'b0;
        tick();
        chk("resume_running", 32'(running), 1);
        chk("resume_phase", 32'(phase), 0);

        // halt_req on the wrap clock goes straight to HALT
        tick();
        tick();
        tick();
        chk("hw_ph3", 32'(phase), 3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        run      = 1'b0;
        chk("hw_tpclk", 32'(tpclk), 1);
        chk("hw_running", 32'(running), 0);
        tick();
        chk("hw_phase", 32'(phase), 0);

        // reset in the wrap clock aborts the cycle
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("mrst_ph3", 32'(phase), 3);
        reset_n = 1'b0;
        #1;
        chk("mrst_phase", 32'(phase), 0);
        chk("mrst_running", 32'(running), 0);
        run = 1'b0;
        tick();
        chk("mrst_tpclk", 32'(tpclk), 0);
        reset_n = 1'b1;
        tick();

`ifdef CADR_CLOCK_STEP_COUNT_EN
        // N=0 load ignored
        step_cnt_load = 1'b1;
        tick();
        step_cnt_load = 1'b0;
        tick();
        tick();
        chk("cnt0_phase", 32'(phase), 0);

        // N=3: three cycles, ack with the third tpclk
        step_cnt      = 16'd3;
        step_cnt_load = 1'b1;
        tick();
        step_cnt_load = 1'b0;
        n_tp  = 0;
        n_ack = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_tp  += int'(tpclk);
            n_ack += int'(step_ack);
            if (i == 11) chk("cnt_ack_tpclk", 32'(step_ack), 1);
        end
        chk("cnt_tpclk_cnt", 32'(n_tp), 3);
        chk("cnt_ack_cnt", 32'(n_ack), 1);
        chk("cnt_end_phase", 32'(phase), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
